dwrr_flow_scheduler: RTL

//  Deficit-weighted round-robin selector for the multi-flow read path of the segment buffer.

---
 rtl/dwrr_flow_scheduler.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/dwrr_flow_scheduler.sv
// Deficit-weighted round-robin flow selector for the segment buffer read path.
// Per-flow credit state lives in dwrr_flow_slot instances. The top-level FSM walks
// rr_ptr and issues one strobe per cycle to the slot that rr_ptr points at.

module dwrr_flow_slot #(
  parameter int MAX_CREDIT_W = 6,
  parameter int DEF_W        = MAX_CREDIT_W + 2,
  parameter int QUANTUM_RST  = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     cfg_we,
  input  logic [MAX_CREDIT_W-1:0]  cfg_quantum,
  input  logic                     clr,
  input  logic                     add,
  input  logic                     drop,
  input  logic                     dec,
  output logic [MAX_CREDIT_W-1:0]  quantum,
  output logic signed [DEF_W-1:0]  deficit,
  output logic                     visited
);
  localparam logic signed [DEF_W-1:0] DEF_MAX = {1'b0, {(DEF_W-1){1'b1}}};
  localparam logic signed [DEF_W-1:0] DEF_MIN = {1'b1, {(DEF_W-1){1'b0}}};
  localparam logic signed [DEF_W-1:0] DEF_ONE = DEF_W'(1);

  logic [DEF_W:0]          sum;
  logic signed [DEF_W-1:0] add_sat;
  logic signed [DEF_W-1:0] dec_sat;

  // Saturating top-up and per-segment charge. The quantum is never negative,
  // so the add can only overflow upward and the decrement only downward.
  always_comb begin
    sum     = {deficit[DEF_W-1], deficit} + {{(DEF_W+1-MAX_CREDIT_W){1'b0}}, quantum};
    add_sat = (sum[DEF_W:DEF_W-1] == 2'b01) ? DEF_MAX : sum[DEF_W-1:0];
    dec_sat = (deficit == DEF_MIN) ? DEF_MIN : deficit - DEF_ONE;
  end

  // Quantum register plus deficit/visited update. Strobes are mutually exclusive
  // by construction; an add on a cfg edge sees the old quantum.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      quantum <= MAX_CREDIT_W'(QUANTUM_RST);
      deficit <= '0;
      visited <= 1'b0;
    end else begin
      if (cfg_we) quantum <= cfg_quantum;
      if (clr) begin
        deficit <= '0;
        visited <= 1'b0;
      end else if (add) begin
        deficit <= add_sat;
        visited <= 1'b1;
      end else if (drop) begin
        visited <= 1'b0;
      end else if (dec) begin
        deficit <= dec_sat;
      end
    end
  end
endmodule

module dwrr_flow_scheduler #(
  parameter int FLOWS_W      = 3,
  parameter int MAX_CREDIT_W = 6,
  parameter int QUANTUM_RST  = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [2**FLOWS_W-1:0]   flow_nonempty,
  output logic                    grant_valid,
  input  logic                    grant_ready,
  output logic [FLOWS_W-1:0]      grant_flow,
  input  logic                    seg_done,
  input  logic                    seg_last,
  output logic                    active,
  input  logic                    cfg_wr,
  input  logic [FLOWS_W-1:0]      cfg_flow,
  input  logic [MAX_CREDIT_W-1:0] cfg_quantum
);
  localparam int FLOWS = 2**FLOWS_W;
  localparam int DEF_W = MAX_CREDIT_W + 2;

  typedef enum logic [1:0] {IDLE, SCAN, GRANT, ACTIVE} state_t;
  state_t state;

  logic [FLOWS_W-1:0]                  rr_ptr;
  logic [FLOWS-1:0][MAX_CREDIT_W-1:0]  quantum;
  logic [FLOWS-1:0][DEF_W-1:0]         deficit;
  logic [FLOWS-1:0]                    visited, eligible, pos;
  logic [FLOWS-1:0]                    clr, add, drop, dec, cfg_we;
  logic                                any_elig, cur_elig, cur_vis, cur_pos;

  genvar i;
  generate
    for (i = 0; i < FLOWS; i++) begin : g_flow
      logic sel;
      assign eligible[i] = flow_nonempty[i] && (quantum[i] != '0);
      assign pos[i]      = !deficit[i][DEF_W-1] && (|deficit[i]);
      assign sel         = (state == SCAN) && any_elig && (rr_ptr == FLOWS_W'(i));
      assign clr[i]      = sel && !eligible[i];
      assign add[i]      = sel && eligible[i] && !visited[i];
      assign drop[i]     = sel && eligible[i] && visited[i] && !pos[i];
      assign dec[i]      = (state == ACTIVE) && seg_done && (grant_flow == FLOWS_W'(i));
      assign cfg_we[i]   = cfg_wr && (cfg_flow == FLOWS_W'(i));

      dwrr_flow_slot #(
        .MAX_CREDIT_W (MAX_CREDIT_W),
        .DEF_W        (DEF_W),
        .QUANTUM_RST  (QUANTUM_RST)
      ) u_slot (
        .clk         (clk),
        .rstn        (rstn),
        .cfg_we      (cfg_we[i]),
        .cfg_quantum (cfg_quantum),
        .clr         (clr[i]),
        .add         (add[i]),
        .drop        (drop[i]),
        .dec         (dec[i]),
        .quantum     (quantum[i]),
        .deficit     (deficit[i]),
        .visited     (visited[i])
      );
    end
  endgenerate

  assign any_elig = |eligible;
  assign cur_elig = eligible[rr_ptr];
  assign cur_vis  = visited[rr_ptr];
  assign cur_pos  = pos[rr_ptr];

  // Scheduler FSM: one scan action per cycle, rr_ptr stays put across a packet so
  // a flow with remaining credit is regranted straight after seg_last.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_valid <= 1'b0;
      grant_flow  <= '0;
      active      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any_elig) state <= SCAN;
        SCAN: begin
          if (!any_elig) begin
            state <= IDLE;
          end else if (!cur_elig) begin
            rr_ptr <= rr_ptr + 1'b1;
          end else if (cur_vis) begin
            if (cur_pos) begin
              grant_flow  <= rr_ptr;
              grant_valid <= 1'b1;
              state       <= GRANT;
            end else begin
              rr_ptr <= rr_ptr + 1'b1;
            end
          end
        end
        GRANT: if (grant_ready) begin
          grant_valid <= 1'b0;
          active      <= 1'b1;
          state       <= ACTIVE;
        end
        ACTIVE: if (seg_done && seg_last) begin
          active <= 1'b0;
          state  <= SCAN;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_no_charge_outside_active: assert property (@(posedge clk) disable iff (!rstn)
    (state != ACTIVE) |-> (dec == '0));
  a_grant_only_in_grant: assert property (@(posedge clk) disable iff (!rstn)
    grant_valid == (state == GRANT));
endmodule
